spi_master_param: RTL and testbench
===================================

SPI_MASTER_PARAM -- requirements
Module: spi_master_param

Interface
REQ-001 Parameter DATA_W, default 12: transfer word width in bits, legal range 4..32.
REQ-002 Parameter CLK_DIV, default 4: clk cycles per SCLK half-period, legal range 1..255.
REQ-003 Parameter NUM_CS, default 2: number of chip selects, legal range 1..8.
REQ-004 clk  in  1  sole clock; all logic on the rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 newd  in  1  transfer request, sampled on the rising edge of clk.
REQ-007 din  in  DATA_W  word to transmit, MSB first.
REQ-008 cs_sel  in  $clog2(NUM_CS) (minimum 1)  target slave index.
REQ-009 cpol, cpha  in  1 each  SPI mode bits.
REQ-010 miso  in  1  serial data from the slave.
REQ-011 sclk  out  1  serial clock.
REQ-012 mosi  out  1  serial data to the slave.
REQ-013 cs_n  out  NUM_CS  active-low chip selects.
REQ-014 dout  out  DATA_W  last received word.
REQ-015 done  out  1  one-cycle pulse marking transfer completion.
REQ-016 busy  out  1  high while a transfer is in progress.

Function
REQ-017 FSM states are IDLE, SETUP, SHIFT and HOLD.
REQ-018 In IDLE, newd=1 with cs_sel<NUM_CS accepts the request at that edge:
- latch din, cs_sel, cpol and cpha;
- set busy=1, drive cs_n[cs_sel]=0 and move to SETUP.
REQ-019 newd is ignored whenever busy=1; newd with cs_sel>=NUM_CS is ignored, with no busy and no cs_n activity.
REQ-020 SETUP lasts CLK_DIV cycles:
- sclk sits at the latched cpol;
- if cpha=0, mosi is driven with the MSB.
REQ-021 SHIFT lasts 2*DATA_W*CLK_DIV cycles, and sclk toggles every CLK_DIV cycles, giving DATA_W leading and DATA_W trailing edges.
REQ-022 cpha=0: miso is sampled on each leading edge, and mosi advances to the next bit on each trailing edge except the last.
REQ-023 cpha=1: mosi presents the next bit on each leading edge (the MSB first), and miso is sampled on each trailing edge.
REQ-024 Received bits shift in MSB first.
REQ-025 HOLD lasts CLK_DIV cycles, with sclk at cpol.
REQ-026 On exit from HOLD, all in the same cycle:
- cs_n returns to all-ones and busy=0;
- dout takes the received word and done=1 for exactly one cycle;
- the FSM returns to IDLE.
REQ-027 Latency from the accepting edge to done high is (2*DATA_W+2)*CLK_DIV cycles.
REQ-028 A new request may be accepted in the cycle after done.
REQ-029 dout holds its value until the next completed transfer.
REQ-030 Changes to din, cs_sel, cpol or cpha during a transfer have no effect.
REQ-031 In IDLE, sclk sits at the last latched cpol and mosi=0.

Reset
REQ-032 rst=0 asynchronously forces all of the following, including mid-transfer:
- FSM to IDLE, sclk=0, mosi=0, cs_n all-ones;
- dout=0, done=0, busy=0;
- latched cpol=0 and cpha=0, and all counters to 0.
REQ-033 No partial word is ever reflected on dout after reset.

Configuration
REQ-034 With SPI_LOOPBACK_EN defined:
- input port lpbk (1 bit) exists;
- when lpbk is latched high at accept, the receiver samples the internal mosi instead of miso, and sclk, mosi and cs_n still toggle normally.
REQ-035 Without SPI_LOOPBACK_EN, the lpbk port and its mux are absent and miso is always sampled.

Structure
REQ-036 Package spi_pkg holds the state enum (spi_state_t), the mode struct (cpol, cpha) and the DATA_W/CLK_DIV default constants.
REQ-037 Sub-module spi_clkgen is a half-period counter that emits lead_stb and trail_stb one-cycle strobes and is enabled only in SHIFT.

Verification
REQ-038 Mode 0, DATA_W=8, CLK_DIV=2, din=8'hA5, miso looped to mosi -> cs_n[0] low, 8 sclk pulses, mosi=10100101, done 36 cycles after accept, dout=8'hA5.
REQ-039 Run all four modes with din=12'h3C6, slave returning 12'h5A9 -> in each mode sclk idles at cpol, sampling follows REQ-022/023, and dout=12'h5A9.
REQ-040 newd pulsed again mid-transfer with din=8'hFF -> ignored; the first word completes and there is exactly one done pulse.
REQ-041 cs_sel=1 with NUM_CS=2, then cs_sel=3 -> cs_n=2'b01 during the first transfer; the second request is ignored and busy stays 0.
REQ-042 rst asserted after 3 sclk pulses -> immediately cs_n=all-ones, busy=0, dout=0, no done; a following normal transfer succeeds.
REQ-043 With SPI_LOOPBACK_EN defined, lpbk=1, din=8'h3C and miso tied to 0 -> dout=8'h3C.

Source files
------------

// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM encoding, SPI mode struct and default sizing for spi_master_param.
package spi_pkg;
  localparam int DEF_DATA_W = 12;
  localparam int DEF_CLK_DIV = 4;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;
  typedef enum logic [1:0] {
    IDLE = S_IDLE,
    SETUP = S_SETUP,
    SHIFT = S_SHIFT,
    HOLD = S_HOLD
  } spi_state_t;
  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;
endpackage

// File: rtl/spi_if.sv
// spi_if: host request/response signals plus SPI pins for spi_master_param.
interface spi_if #(
  parameter int DATA_W = spi_pkg::DEF_DATA_W,
  parameter int NUM_CS = 2
);
  localparam int CSW = NUM_CS > 1 ? $clog2(NUM_CS) : 1;
  logic newd;
  logic [DATA_W-1:0] din;
  logic [CSW-1:0] cs_sel;
  logic cpol;
  logic cpha;
  logic miso;
  logic sclk;
  logic mosi;
  logic [NUM_CS-1:0] cs_n;
  logic [DATA_W-1:0] dout;
  logic done;
  logic busy;
  modport master (
    input newd, din, cs_sel, cpol, cpha, miso,
    output sclk, mosi, cs_n, dout, done, busy
  );
  modport slave (
    output newd, din, cs_sel, cpol, cpha, miso,
    input sclk, mosi, cs_n, dout, done, busy
  );
endinterface

// File: rtl/spi_clkgen.sv
// spi_clkgen: half-period counter; strobes fire on the clk edge where sclk must toggle.
module spi_clkgen import spi_pkg::*; #(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  output logic o_lead_stb,
  output logic o_trail_stb
);
  logic [7:0] r_cnt;
  logic r_ph;
  logic w_hit;
  assign w_hit = i_en && r_cnt == 8'(CLK_DIV - 1);
  assign o_lead_stb = w_hit && !r_ph;
  assign o_trail_stb = w_hit && r_ph;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_cnt <= '0;
      r_ph <= 1'b0;
    end else begin
      r_cnt <= w_hit || !i_en ? '0 : r_cnt + 8'd1;
      r_ph <= !i_en ? 1'b0 : r_ph ^ w_hit;
    end
endmodule

// File: rtl/spi_master_param.sv
// spi_master_param: SPI master with per-transfer mode and chip select, MSB first.
// SPI_LOOPBACK_EN adds port lpbk, which routes the internal mosi into the receiver.
module spi_master_param import spi_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int NUM_CS = 2
) (
  input logic clk,
  input logic rst,
`ifdef SPI_LOOPBACK_EN
  input logic lpbk,
`endif
  spi_if.master bus
);
  spi_state_t r_state;
  spi_mode_t r_mode;
  logic [7:0] r_cnt;
  logic [5:0] r_bit;
  logic [DATA_W-1:0] r_tx, r_rx, r_dout;
  logic [NUM_CS-1:0] r_cs_n;
  logic r_sclk, r_mosi, r_done;
  logic w_lead, w_trail, w_rx_in, w_accept, w_cnt_end, w_last, w_adv, w_sample;
`ifdef SPI_LOOPBACK_EN
  logic r_lpbk;
  assign w_rx_in = r_lpbk ? r_mosi : bus.miso;
`else
  assign w_rx_in = bus.miso;
`endif
  assign w_accept = r_state == IDLE && bus.newd && int'(bus.cs_sel) < NUM_CS;
  assign w_cnt_end = r_cnt == 8'(CLK_DIV - 1);
  assign w_last = r_bit == 6'(DATA_W - 1);
  // cpha=0 preloads the MSB at accept, so only trailing edges (bar the last) advance
  assign w_adv = r_mode.cpha ? w_lead : w_trail && !w_last;
  assign w_sample = r_mode.cpha ? w_trail : w_lead;
  spi_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .clk(clk),
    .rst(rst),
    .i_en(r_state == SHIFT),
    .o_lead_stb(w_lead),
    .o_trail_stb(w_trail)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state <= IDLE;
      r_mode <= '0;
      r_cnt <= '0;
      r_bit <= '0;
      r_tx <= '0;
      r_rx <= '0;
      r_dout <= '0;
      r_cs_n <= '1;
      r_sclk <= 1'b0;
      r_mosi <= 1'b0;
      r_done <= 1'b0;
`ifdef SPI_LOOPBACK_EN
      r_lpbk <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (w_accept) begin
          r_state <= SETUP;
          r_mode <= '{cpol: bus.cpol, cpha: bus.cpha};
          r_sclk <= bus.cpol;
          r_cs_n <= ~(NUM_CS'(1) << bus.cs_sel);
          r_tx <= bus.cpha ? bus.din : bus.din << 1;
          r_mosi <= !bus.cpha && bus.din[DATA_W-1];
`ifdef SPI_LOOPBACK_EN
          r_lpbk <= lpbk;
`endif
        end
        SETUP: begin
          r_cnt <= w_cnt_end ? '0 : r_cnt + 8'd1;
          if (w_cnt_end) r_state <= SHIFT;
        end
        SHIFT: begin
          if (w_lead || w_trail) r_sclk <= ~r_sclk;
          if (w_adv) begin
            r_mosi <= r_tx[DATA_W-1];
            r_tx <= r_tx << 1;
          end
          if (w_sample) r_rx <= {r_rx[DATA_W-2:0], w_rx_in};
          if (w_trail) begin
            r_bit <= w_last ? '0 : r_bit + 6'd1;
            if (w_last) r_state <= HOLD;
          end
        end
        HOLD: begin
          r_cnt <= w_cnt_end ? '0 : r_cnt + 8'd1;
          if (w_cnt_end) begin
            r_state <= IDLE;
            r_cs_n <= '1;
            r_mosi <= 1'b0;
            r_sclk <= r_mode.cpol;
            r_dout <= r_rx;
            r_done <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  assign bus.sclk = r_sclk;
  assign bus.mosi = r_mosi;
  assign bus.cs_n = r_cs_n;
  assign bus.dout = r_dout;
  assign bus.done = r_done;
  assign bus.busy = r_state != IDLE;
endmodule

// File: tb/tb_spi_master_param.sv
// tb_spi_master_param: directed checks on an 8-bit/2-CS and a 12-bit/3-CS instance, CLK_DIV=2.
module tb_spi_master_param;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tie0 = 1'b0;
  logic lpbk8 = 1'b0;
  logic cur_cpha = 1'b0;
  int n_ass = 0, n_fail = 0;
  int p8 = 0, p8b = 0, d8 = 0, ec_raw = 0, ec_base = 0, rel, s_idx, lat;
  logic [7:0] mcap = '0;
  logic [11:0] s_rx = '0;
  logic [11:0] s_word = 12'h5A9;
  logic miso12;
  spi_if #(.DATA_W(8), .NUM_CS(2)) b8();
  spi_if #(.DATA_W(12), .NUM_CS(3)) b12();
  always #5 clk = ~clk;
  spi_master_param #(.DATA_W(8), .CLK_DIV(2), .NUM_CS(2)) u8 (
    .clk(clk), .rst(rst),
`ifdef SPI_LOOPBACK_EN
    .lpbk(lpbk8),
`endif
    .bus(b8.master)
  );
  spi_master_param #(.DATA_W(12), .CLK_DIV(2), .NUM_CS(3)) u12 (
    .clk(clk), .rst(rst),
`ifdef SPI_LOOPBACK_EN
    .lpbk(1'b0),
`endif
    .bus(b12.master)
  );
  assign b8.miso = tie0 ? 1'b0 : b8.mosi;
  assign b12.miso = miso12;
  always @(posedge b8.sclk) begin
    p8++;
    mcap = {mcap[6:0], b8.mosi};
  end
  always @(posedge clk) if (b8.done === 1'b1) d8++;
  // Slave model for the 12-bit instance: bit index follows the sclk edge count since accept
  assign rel = ec_raw - ec_base;
  always_comb begin
    s_idx = cur_cpha ? (rel + 1) / 2 - 1 : rel / 2;
    if (s_idx < 0) s_idx = 0;
    if (s_idx > 11) s_idx = 11;
    miso12 = s_word[11 - s_idx];
  end
  always @(b12.sclk) begin
    if (b12.cs_n[0] === 1'b0 && (((ec_raw - ec_base) & 1) == 1) == cur_cpha) s_rx = {s_rx[10:0], b12.mosi};
    ec_raw++;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_ass++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic start8(input logic [7:0] d, input logic cs, input logic pol, input logic pha);
    @(negedge clk);
    b8.din = d; b8.cs_sel = cs; b8.cpol = pol; b8.cpha = pha; b8.newd = 1'b1;
    @(posedge clk); #1;
    b8.newd = 1'b0;
    p8b = p8;
  endtask
  task automatic start12(input logic [11:0] d, input logic [1:0] cs, input logic pol, input logic pha);
    @(negedge clk);
    cur_cpha = pha;
    b12.din = d; b12.cs_sel = cs; b12.cpol = pol; b12.cpha = pha; b12.newd = 1'b1;
    @(posedge clk); #1;
    b12.newd = 1'b0;
    ec_base = ec_raw;
  endtask
  task automatic wait_done(input bit w12, output int l);
    l = -1;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk); #1;
      if ((w12 ? b12.done : b8.done) === 1'b1) begin
        l = i;
        break;
      end
    end
  endtask
  initial begin
    b8.newd = 0; b8.din = '0; b8.cs_sel = '0; b8.cpol = 0; b8.cpha = 0;
    b12.newd = 0; b12.din = '0; b12.cs_sel = '0; b12.cpol = 0; b12.cpha = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs_n", 32'(b8.cs_n), 32'h3);
    chk("rst_busy", 32'(b8.busy), 32'h0);
    chk("rst_dout", 32'(b8.dout), 32'h0);
    chk("rst_done", 32'(b8.done), 32'h0);
    chk("rst_sclk_mosi", 32'({b8.sclk, b8.mosi}), 32'h0);
    @(negedge clk) rst = 1'b1;
    // mode 0 loopback through miso
    start8(8'hA5, 1'b0, 1'b0, 1'b0);
    chk("acc_cs_n", 32'(b8.cs_n), 32'h2);
    chk("acc_busy", 32'(b8.busy), 32'h1);
    chk("acc_mosi_msb", 32'(b8.mosi), 32'h1);
    wait_done(1'b0, lat);
    chk("lat8", 32'(lat), 32'd36);
    chk("dout_a5", 32'(b8.dout), 32'hA5);
    chk("mosi_seq", 32'(mcap), 32'hA5);
    chk("sclk_pulses", 32'(p8 - p8b), 32'd8);
    chk("done_cs_n", 32'(b8.cs_n), 32'h3);
    chk("done_busy", 32'(b8.busy), 32'h0);
    @(posedge clk); #1;
    chk("done_pulse_len", 32'(b8.done), 32'h0);
    chk("idle_mosi", 32'(b8.mosi), 32'h0);
    // newd during transfer is ignored
    d8 = 0;
    start8(8'h5C, 1'b0, 1'b0, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    b8.din = 8'hFF; b8.newd = 1'b1;
    @(posedge clk); #1;
    b8.newd = 1'b0;
    b8.din = 8'h00;
    chk("mid_busy", 32'(b8.busy), 32'h1);
    wait_done(1'b0, lat);
    chk("mid_dout", 32'(b8.dout), 32'h5C);
    repeat (60) @(posedge clk);
    #1;
    chk("mid_one_done", 32'(d8), 32'd1);
    chk("mid_idle", 32'(b8.busy), 32'h0);
    // chip select 1, then an out-of-range select on the 3-CS instance
    start8(8'hC3, 1'b1, 1'b0, 1'b0);
    chk("cs1_cs_n", 32'(b8.cs_n), 32'h1);
    wait_done(1'b0, lat);
    chk("cs1_dout", 32'(b8.dout), 32'hC3);
    start12(12'h123, 2'd3, 1'b0, 1'b0);
    chk("cs3_busy", 32'(b12.busy), 32'h0);
    chk("cs3_cs_n", 32'(b12.cs_n), 32'h7);
    repeat (5) @(posedge clk);
    #1;
    chk("cs3_busy_later", 32'(b12.busy), 32'h0);
    // all four modes on the 12-bit instance
    for (int m = 0; m < 4; m++) begin
      start12(12'h3C6, 2'd0, m[1], m[0]);
      chk($sformatf("m%0d_setup_sclk", m), 32'(b12.sclk), 32'(m[1]));
      chk($sformatf("m%0d_cs_n", m), 32'(b12.cs_n), 32'h6);
      wait_done(1'b1, lat);
      chk($sformatf("m%0d_lat", m), 32'(lat), 32'd52);
      chk($sformatf("m%0d_dout", m), 32'(b12.dout), 32'h5A9);
      chk($sformatf("m%0d_slave_rx", m), 32'(s_rx), 32'h3C6);
      chk($sformatf("m%0d_idle_sclk", m), 32'(b12.sclk), 32'(m[1]));
    end
    // reset mid-transfer after three sclk pulses
    d8 = 0;
    start8(8'h96, 1'b0, 1'b0, 1'b0);
    lat = -1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (p8 - p8b >= 3) begin
        lat = i;
        break;
      end
    end
    chk("rst_wait_3_pulses", 32'(lat >= 0), 32'h1);
    #2 rst = 1'b0;
    #1;
    chk("mrst_cs_n", 32'(b8.cs_n), 32'h3);
    chk("mrst_busy", 32'(b8.busy), 32'h0);
    chk("mrst_dout", 32'(b8.dout), 32'h0);
    chk("mrst_sclk", 32'(b8.sclk), 32'h0);
    @(negedge clk) rst = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("mrst_no_done", 32'(d8), 32'd0);
    start8(8'h3A, 1'b0, 1'b0, 1'b0);
    wait_done(1'b0, lat);
    chk("post_rst_lat", 32'(lat), 32'd36);
    chk("post_rst_dout", 32'(b8.dout), 32'h3A);
`ifdef SPI_LOOPBACK_EN
    tie0 = 1'b1;
    lpbk8 = 1'b1;
    start8(8'h3C, 1'b0, 1'b0, 1'b0);
    wait_done(1'b0, lat);
    chk("lpbk_dout", 32'(b8.dout), 32'h3C);
    tie0 = 1'b0;
    lpbk8 = 1'b0;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_ass, n_fail);
    $finish;
  end
endmodule
